// File: rtl/sobel_window_feeder.sv
// Streaming 3x3 window generator: two cascaded line buffers plus three row shift registers
// turn a raster pixel stream into top/mid/bottom triplets for the Sobel multiplier.
//
// state | meaning
// IDLE  | after reset, waiting for frameStart, pixels ignored
// FILL  | frame in progress, no complete window seen yet
// RUN   | frame in progress, windows being produced
// DONE  | last pixel accepted, pixels ignored until frameStart
module sobel_window_feeder #(
    parameter int IMGW = 1024,
    parameter int IMGH = 1024,
    parameter int PICW = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frameStart,
    input  logic [7:0]  pixelIn,
    input  logic        pixelValid,
    output logic [23:0] sobelHoldOutA,
    output logic [23:0] sobelHoldOutB,
    output logic [23:0] sobelHoldOutC,
    output logic        windowValid,
    output logic        startMultiplierEn,
    output logic        frameDone
);

    localparam int AW = (IMGW > 1) ? $clog2(IMGW) : 1;
    localparam logic [PICW-1:0] LAST_COL = PICW'(IMGW - 1);
    localparam logic [PICW-1:0] LAST_ROW = PICW'(IMGH - 1);
    localparam logic [PICW-1:0] TWO      = PICW'(2);
    localparam logic [PICW-1:0] ONE      = PICW'(1);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t          state;
    logic [PICW-1:0] col;
    logic [PICW-1:0] row;
    logic [PICW-1:0] pos_col;
    logic [PICW-1:0] pos_row;
    logic [AW-1:0]   addr;
    logic            accept;
    logic            win;
    logic            last;
    logic [7:0]      top_px;
    logic [7:0]      mid_px;

    // lb_mid holds line r-1, lb_top holds line r-2; data cascades mid -> top on each write
    logic [7:0] lb_mid [IMGW];
    logic [7:0] lb_top [IMGW];

    // frameStart makes the pixel of the same cycle (0,0) regardless of the running counters
    assign pos_col = frameStart ? '0 : col;
    assign pos_row = frameStart ? '0 : row;
    assign addr    = pos_col[AW-1:0];
    assign accept  = pixelValid && (frameStart || state == FILL || state == RUN);
    assign win     = (pos_row >= TWO) && (pos_col >= TWO);
    assign last    = (pos_row == LAST_ROW) && (pos_col == LAST_COL);
    assign top_px  = lb_top[addr];
    assign mid_px  = lb_mid[addr];

    always_ff @(posedge clk) begin
        if (accept) begin
            lb_mid[addr] <= pixelIn;
            lb_top[addr] <= mid_px;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            col               <= '0;
            row               <= '0;
            sobelHoldOutA     <= '0;
            sobelHoldOutB     <= '0;
            sobelHoldOutC     <= '0;
            windowValid       <= 1'b0;
            startMultiplierEn <= 1'b0;
            frameDone         <= 1'b0;
        end else begin
            windowValid <= 1'b0;
            frameDone   <= 1'b0;
            // enable stays up through the frameDone cycle, drops on the following edge
            if (frameDone) begin
                startMultiplierEn <= 1'b0;
            end
            if (frameStart) begin
                state             <= FILL;
                col               <= '0;
                row               <= '0;
                startMultiplierEn <= 1'b0;
            end
            if (accept) begin
                sobelHoldOutA <= {sobelHoldOutA[15:0], top_px};
                sobelHoldOutB <= {sobelHoldOutB[15:0], mid_px};
                sobelHoldOutC <= {sobelHoldOutC[15:0], pixelIn};
                if (pos_col == LAST_COL) begin
                    col <= '0;
                    row <= pos_row + ONE;
                end else begin
                    col <= pos_col + ONE;
                    row <= pos_row;
                end
                if (win) begin
                    windowValid       <= 1'b1;
                    startMultiplierEn <= 1'b1;
                end
                if (last) begin
                    state     <= DONE;
                    frameDone <= 1'b1;
                end else if (win) begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_sobel_window_feeder.sv
// Directed bench for sobel_window_feeder: 8x4 ramp frames with gaps, restarts and reset,
// plus a 1024x3 constant frame on a second instance.
module tb_sobel_window_feeder;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        frameStart = 1'b0;
    logic        pixelValid = 1'b0;
    logic [7:0]  pixelIn = '0;
    logic [23:0] hold_a, hold_b, hold_c;
    logic        wvalid, mult_en, fdone;

    logic        fs6 = 1'b0;
    logic        pv6 = 1'b0;
    logic [7:0]  px6 = '0;
    logic [23:0] a6, b6, c6;
    logic        wv6, en6, fd6;

    int n_vec = 0;
    int n_err = 0;

    bit exp_en = 0;
    bit prev_fd = 0;
    bit prev_win = 0;
    int prev_r = 0;
    int prev_c = 0;
    int win_cnt = 0;

    sobel_window_feeder #(.IMGW(W), .IMGH(H), .PICW(24)) dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .pixelIn(pixelIn),
        .pixelValid(pixelValid), .sobelHoldOutA(hold_a), .sobelHoldOutB(hold_b),
        .sobelHoldOutC(hold_c), .windowValid(wvalid), .startMultiplierEn(mult_en),
        .frameDone(fdone)
    );

    sobel_window_feeder #(.IMGW(1024), .IMGH(3), .PICW(24)) dut6 (
        .clk(clk), .reset(reset), .frameStart(fs6), .pixelIn(px6),
        .pixelValid(pv6), .sobelHoldOutA(a6), .sobelHoldOutB(b6),
        .sobelHoldOutC(c6), .windowValid(wv6), .startMultiplierEn(en6),
        .frameDone(fd6)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(16 * r + c);
    endfunction

    function automatic logic [23:0] row3(input int r, input int c);
        return {pix(r, c - 2), pix(r, c - 1), pix(r, c)};
    endfunction

    task automatic step_pixel(input logic fs, input int r, input int c);
        bit win, last;
        @(negedge clk);
        frameStart = fs;
        pixelValid = 1'b1;
        pixelIn    = pix(r, c);
        @(posedge clk);
        #1;
        frameStart = 1'b0;
        pixelValid = 1'b0;
        win  = (r >= 2) && (c >= 2);
        last = (r == H - 1) && (c == W - 1);
        if (prev_fd || fs) exp_en = 0;
        if (win) exp_en = 1;
        if (wvalid) win_cnt++;
        check("wvalid", wvalid, win);
        check("frame_done", fdone, last);
        check("mult_en", mult_en, exp_en);
        if (win) begin
            check("row_a", hold_a, row3(r - 2, c));
            check("row_b", hold_b, row3(r - 1, c));
            check("row_c", hold_c, row3(r, c));
        end
        prev_fd  = last;
        prev_win = win;
        prev_r   = r;
        prev_c   = c;
    endtask

    task automatic gap_cycle();
        @(negedge clk);
        @(posedge clk);
        #1;
        if (prev_fd) exp_en = 0;
        prev_fd = 0;
        check("gap_wvalid", wvalid, 1'b0);
        check("gap_done", fdone, 1'b0);
        check("gap_en", mult_en, exp_en);
        if (prev_win) begin
            check("gap_a", hold_a, row3(prev_r - 2, prev_c));
            check("gap_b", hold_b, row3(prev_r - 1, prev_c));
            check("gap_c", hold_c, row3(prev_r, prev_c));
        end
    endtask

    task automatic send_frame(input bit gaps, input int npix);
        for (int idx = 0; idx < npix; idx++) begin
            step_pixel(idx == 0, idx / W, idx % W);
            if (gaps) gap_cycle();
        end
    endtask

    initial begin
        int w6, e6;
        #1;
        check("rst_a", hold_a, 24'h0);
        check("rst_wv", wvalid, 1'b0);
        check("rst_en", mult_en, 1'b0);
        check("rst_fd", fdone, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // ramp frame, continuous
        win_cnt = 0;
        send_frame(0, W * H);
        check("t1_windows", win_cnt, 12);
        gap_cycle();
        check("t1_en_off", mult_en, 1'b0);

        // same frame with one-cycle gaps between pixels
        win_cnt = 0;
        send_frame(1, W * H);
        check("t2_windows", win_cnt, 12);

        // line wrap: (3,0) and (3,1) give no window, (3,2) does
        send_frame(0, 3 * W + 3);
        check("t3_wv_r3c2", wvalid, 1'b1);
        check("t3_c_r3c2", hold_c, 24'h303132);
        check("t3_b_r3c2", hold_b, 24'h202122);

        // restart in the middle of a frame at what would be pixel (2,5)
        send_frame(0, 2 * W + 5);
        check("t4_en_before", mult_en, 1'b1);
        win_cnt = 0;
        send_frame(0, W * H);
        check("t4_windows", win_cnt, 12);

        // async reset mid-RUN
        send_frame(0, 2 * W + 4);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("t5_a", hold_a, 24'h0);
        check("t5_b", hold_b, 24'h0);
        check("t5_c", hold_c, 24'h0);
        check("t5_wv", wvalid, 1'b0);
        check("t5_en", mult_en, 1'b0);
        #2;
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            pixelValid = 1'b1;
            pixelIn    = 8'h55;
            @(posedge clk);
            #1;
            pixelValid = 1'b0;
            check("t5_ign_wv", wvalid, 1'b0);
            check("t5_ign_c", hold_c, 24'h0);
        end
        exp_en  = 0;
        prev_fd = 0;
        win_cnt = 0;
        send_frame(0, W * H);
        check("t5_windows", win_cnt, 12);

        // 1024x3 constant frame on the wide instance
        w6 = 0;
        e6 = 0;
        for (int idx = 0; idx < 3 * 1024; idx++) begin
            @(negedge clk);
            fs6 = (idx == 0);
            pv6 = 1'b1;
            px6 = 8'hFF;
            @(posedge clk);
            #1;
            fs6 = 1'b0;
            pv6 = 1'b0;
            if (en6) e6++;
            check("t6_wv", wv6, (idx / 1024 == 2) && (idx % 1024 >= 2));
            if (wv6) begin
                w6++;
                check("t6_a", a6, 24'hFFFFFF);
                check("t6_b", b6, 24'hFFFFFF);
                check("t6_c", c6, 24'hFFFFFF);
            end
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            if (en6) e6++;
        end
        check("t6_windows", w6, 1022);
        check("t6_en_cycles", e6, 1022);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
